// File: rtl/dec_issue.sv
// dec_issue: decode/issue stage between ifetch and execute.
// Decodes one RV32I instruction per cycle, resolves operands through NB_FF prioritised
// forwarding sources (index 0 youngest), stalls on load-use hazards by inserting bubbles,
// holds a registered payload under execute backpressure and counts stall cycles.
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   if_valid_i / dec_ready_o       fetch-side handshake; instr_q_i, pc0_q_i
//   rf_rs*_adr_o / rf_rs*_data_i   register file read
//   csr_adr_o / csr_data_i         CSR read; exe_ff_csr_data_i forwards the issued CSR result
//   ff_v_i/ff_pend_i/ff_adr_i/ff_data_i  forwarding sources, source 0 in LSBs
//   exe_valid_q_o / exe_ready_i    execute-side handshake; *_q_o payload registers
//   stall_cnt_q_o                  saturating load-use stall cycle counter
//   flush_v_i                      pipeline flush, highest priority
module dec_issue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NB_FF = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    if_valid_i,
  output logic                    dec_ready_o,
  input  logic [XLEN-1:0]         instr_q_i,
  input  logic [XLEN-1:0]         pc0_q_i,
  output logic [4:0]              rf_rs1_adr_o,
  output logic [4:0]              rf_rs2_adr_o,
  input  logic [XLEN-1:0]         rf_rs1_data_i,
  input  logic [XLEN-1:0]         rf_rs2_data_i,
  output logic [11:0]             csr_adr_o,
  input  logic [XLEN-1:0]         csr_data_i,
  input  logic [NB_FF-1:0]        ff_v_i,
  input  logic [NB_FF-1:0]        ff_pend_i,
  input  logic [NB_FF*5-1:0]      ff_adr_i,
  input  logic [NB_FF*XLEN-1:0]   ff_data_i,
  input  logic [XLEN-1:0]         exe_ff_csr_data_i,
  output logic                    exe_valid_q_o,
  input  logic                    exe_ready_i,
  output logic [XLEN-1:0]         pc_q_o,
  output logic                    rd_v_q_o,
  output logic [4:0]              rd_adr_q_o,
  output logic                    csr_wbk_q_o,
  output logic [11:0]             csr_adr_q_o,
  output logic [XLEN:0]           rs1_data_qual_q_o,
  output logic [XLEN:0]           rs2_data_qual_q_o,
  output logic [XLEN-1:0]         branch_imm_q_o,
  output logic [1:0]              access_size_q_o,
  output logic                    unsign_ext_q_o,
  output logic                    csrrw_q_o,
  output logic [1:0]              unit_q_o,
  output logic [3:0]              operation_q_o,
  output logic                    illegal_inst_q_o,
  output logic [CNT_W-1:0]        stall_cnt_q_o,
  input  logic                    flush_v_i
);

  localparam logic [1:0] UnitAlu = 2'd0, UnitBranch = 2'd1, UnitLsu = 2'd2, UnitCsr = 2'd3;

  typedef enum logic [1:0] {StRun, StStall, StHold} state_e;
  state_e state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  assign opcode = instr_q_i[6:0];
  assign funct3 = instr_q_i[14:12];

  assign rf_rs1_adr_o = instr_q_i[19:15];
  assign rf_rs2_adr_o = instr_q_i[24:20];
  assign csr_adr_o    = instr_q_i[31:20];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, zimm, four;
  assign imm_i = {{(XLEN-12){instr_q_i[31]}}, instr_q_i[31:20]};
  assign imm_s = {{(XLEN-12){instr_q_i[31]}}, instr_q_i[31:25], instr_q_i[11:7]};
  assign imm_b = {{(XLEN-12){instr_q_i[31]}}, instr_q_i[7], instr_q_i[30:25], instr_q_i[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){instr_q_i[31]}}, instr_q_i[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){instr_q_i[31]}}, instr_q_i[19:12], instr_q_i[20], instr_q_i[30:21],
                  1'b0};
  assign zimm  = {{(XLEN-5){1'b0}}, instr_q_i[19:15]};
  assign four  = {{(XLEN-3){1'b0}}, 3'd4};

  // Decoder
  logic            rs1_v, rs2_v, rd_v, op1_pc, op1_zimm, op2_imm, op2_four, op2_csr;
  logic            unsign, csr_clear, ca2, unsign_ext, csr_wbk, csrrw, illegal;
  logic [XLEN-1:0] imm, branch_imm;
  logic [1:0]      unit, access_size;
  logic [3:0]      operation;

  always_comb begin
    rs1_v = 1'b0; rs2_v = 1'b0; rd_v = 1'b0;
    op1_pc = 1'b0; op1_zimm = 1'b0; op2_imm = 1'b0; op2_four = 1'b0; op2_csr = 1'b0;
    unsign = 1'b0; csr_clear = 1'b0; ca2 = 1'b0; unsign_ext = 1'b0;
    csr_wbk = 1'b0; csrrw = 1'b0; illegal = 1'b0;
    imm = '0; branch_imm = '0; unit = UnitAlu; access_size = 2'd0; operation = 4'd0;
    unique case (opcode)
      7'b0110011: begin // OP
        rs1_v = 1'b1; rs2_v = 1'b1; rd_v = 1'b1;
        operation = {instr_q_i[30], funct3};
        // SUB and SLT/SLTU subtract rs2
        ca2 = (instr_q_i[30] && funct3 == 3'b000) || funct3[2:1] == 2'b01;
        unsign = (funct3 == 3'b011);
      end
      7'b0010011: begin // OP-IMM
        rs1_v = 1'b1; rd_v = 1'b1; op2_imm = 1'b1; imm = imm_i;
        operation = {instr_q_i[30] && funct3 == 3'b101, funct3};
        ca2 = (funct3[2:1] == 2'b01);
        unsign = (funct3 == 3'b011);
      end
      7'b0110111: begin // LUI: rs1 unused, operand 1 reads zero
        rd_v = 1'b1; op2_imm = 1'b1; imm = imm_u;
      end
      7'b0010111: begin // AUIPC
        rd_v = 1'b1; op1_pc = 1'b1; op2_imm = 1'b1; imm = imm_u;
      end
      7'b1101111: begin // JAL: link = pc + 4
        rd_v = 1'b1; op1_pc = 1'b1; op2_four = 1'b1; unit = UnitBranch;
        branch_imm = imm_j; operation = 4'b1000;
      end
      7'b1100111: begin // JALR: target = rs1 + imm, link from pc_q_o
        rs1_v = 1'b1; rd_v = 1'b1; op2_four = 1'b1; unit = UnitBranch;
        branch_imm = imm_i; operation = 4'b1001;
      end
      7'b1100011: begin // BRANCH: compare by subtraction
        rs1_v = 1'b1; rs2_v = 1'b1; unit = UnitBranch; ca2 = 1'b1;
        unsign = funct3[1]; branch_imm = imm_b; operation = {1'b0, funct3};
      end
      7'b0000011: begin // LOAD
        rs1_v = 1'b1; rd_v = 1'b1; op2_imm = 1'b1; imm = imm_i; unit = UnitLsu;
        access_size = funct3[1:0]; unsign_ext = funct3[2]; operation = {1'b0, funct3};
      end
      7'b0100011: begin // STORE: address offset travels in branch_imm
        rs1_v = 1'b1; rs2_v = 1'b1; unit = UnitLsu; branch_imm = imm_s;
        access_size = funct3[1:0]; operation = {1'b1, funct3};
      end
      7'b1110011: begin // SYSTEM: only CSR accesses are supported
        if (funct3 != 3'b000) begin
          rd_v = 1'b1; rs1_v = ~funct3[2]; op1_zimm = funct3[2]; op2_csr = 1'b1;
          unit = UnitCsr; unsign = 1'b1; csr_wbk = 1'b1;
          csr_clear = (funct3[1:0] == 2'b11);  // CSRRC: execute ANDs csr with ~rs1
          csrrw = (funct3[1:0] == 2'b01);
          operation = {1'b0, funct3};
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  // Returns {pend, data}; lowest index wins, x0 is never forwarded.
  function automatic logic [XLEN:0] fwd_sel(input logic [4:0] adr, input logic [XLEN-1:0] rf);
    logic [XLEN:0] r;
    r = {1'b0, rf};
    for (int i = int'(NB_FF) - 1; i >= 0; i--) begin
      if (ff_v_i[i] && ff_adr_i[i*5 +: 5] == adr) r = {ff_pend_i[i], ff_data_i[i*XLEN +: XLEN]};
    end
    if (adr == 5'd0) r = '0;
    return r;
  endfunction

  logic [XLEN:0]   rs1_fwd, rs2_fwd, ext2, q1, q2;
  logic [XLEN-1:0] csr_data, op1, op2;
  logic            hazard, load_en;

  assign rs1_fwd = fwd_sel(rf_rs1_adr_o, rf_rs1_data_i);
  assign rs2_fwd = fwd_sel(rf_rs2_adr_o, rf_rs2_data_i);
  assign hazard  = (rs1_v & rs1_fwd[XLEN]) | (rs2_v & rs2_fwd[XLEN]);

  assign csr_data = (exe_valid_q_o && csr_wbk_q_o && csr_adr_q_o == csr_adr_o) ?
                    exe_ff_csr_data_i : csr_data_i;

  assign op1 = op1_pc   ? pc0_q_i :
               op1_zimm ? zimm :
               rs1_v    ? rs1_fwd[XLEN-1:0] : '0;
  assign op2 = op2_csr  ? csr_data :
               op2_imm  ? imm :
               op2_four ? four : rs2_fwd[XLEN-1:0];

  assign q1   = {~unsign & op1[XLEN-1], csr_clear ? ~op1 : op1};
  assign ext2 = {~unsign & op2[XLEN-1], op2};
  assign q2   = ca2 ? (~ext2 + {{XLEN{1'b0}}, 1'b1}) : ext2;

  assign load_en     = ~exe_valid_q_o | exe_ready_i;
  assign dec_ready_o = ~hazard & load_en & ~flush_v_i;

  always_comb begin
    state_d = StRun;
    if (flush_v_i)                          state_d = StRun;
    else if (exe_valid_q_o && !exe_ready_i) state_d = StHold;
    else if (if_valid_i && hazard)          state_d = StStall;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StRun;
      exe_valid_q_o <= 1'b0;
      stall_cnt_q_o <= '0;
    end else begin
      state_q <= state_d;
      if (flush_v_i)    exe_valid_q_o <= 1'b0;
      else if (load_en) exe_valid_q_o <= if_valid_i & ~hazard;
      if (state_q == StStall && !flush_v_i && stall_cnt_q_o != {CNT_W{1'b1}}) begin
        stall_cnt_q_o <= stall_cnt_q_o + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q_o            <= '0;
      rd_v_q_o          <= 1'b0;
      rd_adr_q_o        <= '0;
      csr_wbk_q_o       <= 1'b0;
      csr_adr_q_o       <= '0;
      rs1_data_qual_q_o <= '0;
      rs2_data_qual_q_o <= '0;
      branch_imm_q_o    <= '0;
      access_size_q_o   <= '0;
      unsign_ext_q_o    <= 1'b0;
      csrrw_q_o         <= 1'b0;
      unit_q_o          <= '0;
      operation_q_o     <= '0;
      illegal_inst_q_o  <= 1'b0;
    end else if (load_en) begin
      pc_q_o            <= pc0_q_i;
      rd_v_q_o          <= rd_v & (instr_q_i[11:7] != 5'd0);
      rd_adr_q_o        <= instr_q_i[11:7];
      csr_wbk_q_o       <= csr_wbk;
      csr_adr_q_o       <= csr_adr_o;
      rs1_data_qual_q_o <= q1;
      rs2_data_qual_q_o <= q2;
      branch_imm_q_o    <= branch_imm;
      access_size_q_o   <= access_size;
      unsign_ext_q_o    <= unsign_ext;
      csrrw_q_o         <= csrrw;
      unit_q_o          <= unit;
      operation_q_o     <= operation;
      illegal_inst_q_o  <= illegal;
    end
  end

endmodule

// File: tb/tb_dec_issue.sv
// Directed bench for dec_issue: forwarding priority, load-use stall, backpressure hold,
// flush during stall, two's-complement operand, asynchronous reset mid-hold.
module tb_dec_issue;
  localparam int unsigned XLEN = 32, NB_FF = 2, CNT_W = 16;

  localparam logic [31:0] AddiX1X0_5  = 32'h0050_0093;
  localparam logic [31:0] AddX2X1X1   = 32'h0010_8133;
  localparam logic [31:0] AddX4X3X0   = 32'h0001_8233;
  localparam logic [31:0] AddX6X5X5   = 32'h0052_8333;
  localparam logic [31:0] SubX1X2X3   = 32'h4031_00B3;

  logic clk = 1'b0, reset_n;
  logic if_valid_i, dec_ready_o, exe_valid_q_o, exe_ready_i, flush_v_i;
  logic [XLEN-1:0] instr_q_i, pc0_q_i, rf_rs1_data_i, rf_rs2_data_i, csr_data_i;
  logic [XLEN-1:0] exe_ff_csr_data_i, pc_q_o, branch_imm_q_o;
  logic [4:0] rf_rs1_adr_o, rf_rs2_adr_o, rd_adr_q_o;
  logic [11:0] csr_adr_o, csr_adr_q_o;
  logic [NB_FF-1:0] ff_v_i, ff_pend_i;
  logic [NB_FF*5-1:0] ff_adr_i;
  logic [NB_FF*XLEN-1:0] ff_data_i;
  logic rd_v_q_o, csr_wbk_q_o, unsign_ext_q_o, csrrw_q_o, illegal_inst_q_o;
  logic [XLEN:0] rs1_data_qual_q_o, rs2_data_qual_q_o;
  logic [1:0] access_size_q_o, unit_q_o;
  logic [3:0] operation_q_o;
  logic [CNT_W-1:0] stall_cnt_q_o;

  int passes = 0, total = 0;

  always #5 clk = ~clk;

  dec_issue #(.XLEN(XLEN), .NB_FF(NB_FF), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .if_valid_i(if_valid_i), .dec_ready_o(dec_ready_o),
    .instr_q_i(instr_q_i), .pc0_q_i(pc0_q_i), .rf_rs1_adr_o(rf_rs1_adr_o),
    .rf_rs2_adr_o(rf_rs2_adr_o), .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
    .csr_adr_o(csr_adr_o), .csr_data_i(csr_data_i), .ff_v_i(ff_v_i), .ff_pend_i(ff_pend_i),
    .ff_adr_i(ff_adr_i), .ff_data_i(ff_data_i), .exe_ff_csr_data_i(exe_ff_csr_data_i),
    .exe_valid_q_o(exe_valid_q_o), .exe_ready_i(exe_ready_i), .pc_q_o(pc_q_o),
    .rd_v_q_o(rd_v_q_o), .rd_adr_q_o(rd_adr_q_o), .csr_wbk_q_o(csr_wbk_q_o),
    .csr_adr_q_o(csr_adr_q_o), .rs1_data_qual_q_o(rs1_data_qual_q_o),
    .rs2_data_qual_q_o(rs2_data_qual_q_o), .branch_imm_q_o(branch_imm_q_o),
    .access_size_q_o(access_size_q_o), .unsign_ext_q_o(unsign_ext_q_o), .csrrw_q_o(csrrw_q_o),
    .unit_q_o(unit_q_o), .operation_q_o(operation_q_o), .illegal_inst_q_o(illegal_inst_q_o),
    .stall_cnt_q_o(stall_cnt_q_o), .flush_v_i(flush_v_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; if_valid_i = 1'b0; exe_ready_i = 1'b1; flush_v_i = 1'b0;
    instr_q_i = '0; pc0_q_i = '0; rf_rs1_data_i = '0; rf_rs2_data_i = '0;
    csr_data_i = '0; exe_ff_csr_data_i = '0;
    ff_v_i = '0; ff_pend_i = '0; ff_adr_i = '0; ff_data_i = '0;
    #3;
    chk("reset_exe_valid", 64'(exe_valid_q_o), 64'd0);
    chk("reset_stall_cnt", 64'(stall_cnt_q_o), 64'd0);
    chk("reset_pc", 64'(pc_q_o), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    tick();

    // 1: back-to-back issue, ADD forwards x1 from source 0
    instr_q_i = AddiX1X0_5; pc0_q_i = 32'h100; if_valid_i = 1'b1;
    ff_v_i = 2'b01; ff_adr_i = {5'd0, 5'd1}; ff_data_i = {32'd0, 32'd5};
    #1 chk("t1_ready", 64'(dec_ready_o), 64'd1);
    tick();
    chk("t1_addi_valid", 64'(exe_valid_q_o), 64'd1);
    chk("t1_addi_rs1", 64'(rs1_data_qual_q_o), 64'd0);
    chk("t1_addi_rs2", 64'(rs2_data_qual_q_o), 64'd5);
    chk("t1_addi_rd", 64'(rd_adr_q_o), 64'd1);
    instr_q_i = AddX2X1X1; pc0_q_i = 32'h104;
    tick();
    chk("t1_add_valid", 64'(exe_valid_q_o), 64'd1);
    chk("t1_add_pc", 64'(pc_q_o), 64'h104);
    chk("t1_add_rs1", 64'(rs1_data_qual_q_o), 64'd5);
    chk("t1_add_rs2", 64'(rs2_data_qual_q_o), 64'd5);

    // 2: priority between sources, x0 never forwarded, RF fallback
    instr_q_i = AddX4X3X0; pc0_q_i = 32'h108;
    rf_rs1_data_i = 32'h11; rf_rs2_data_i = 32'h22;
    ff_v_i = 2'b11; ff_adr_i = {5'd3, 5'd3}; ff_data_i = {32'd9, 32'd7};
    #1 chk("t2_rs1_adr", 64'(rf_rs1_adr_o), 64'd3);
    tick();
    chk("t2_prio_rs1", 64'(rs1_data_qual_q_o), 64'd7);
    chk("t2_x0_rs2", 64'(rs2_data_qual_q_o), 64'd0);
    ff_adr_i = {5'd3, 5'd0}; ff_data_i = {32'd9, 32'hAB}; pc0_q_i = 32'h10C;
    tick();
    chk("t2_src1_rs1", 64'(rs1_data_qual_q_o), 64'd9);
    chk("t2_x0_valid_ff", 64'(rs2_data_qual_q_o), 64'd0);
    ff_v_i = 2'b00;
    tick();
    chk("t2_rf_rs1", 64'(rs1_data_qual_q_o), 64'h11);

    // 3: load-use stall for two cycles
    instr_q_i = AddX6X5X5; pc0_q_i = 32'h200;
    ff_v_i = 2'b01; ff_pend_i = 2'b01; ff_adr_i = {5'd0, 5'd5}; ff_data_i = {32'd0, 32'h33};
    #1 chk("t3_ready_a", 64'(dec_ready_o), 64'd0);
    tick();
    chk("t3_bubble_a", 64'(exe_valid_q_o), 64'd0);
    chk("t3_cnt_a", 64'(stall_cnt_q_o), 64'd0);
    #1 chk("t3_ready_b", 64'(dec_ready_o), 64'd0);
    tick();
    chk("t3_bubble_b", 64'(exe_valid_q_o), 64'd0);
    chk("t3_cnt_b", 64'(stall_cnt_q_o), 64'd1);
    ff_pend_i = 2'b00;
    #1 chk("t3_ready_c", 64'(dec_ready_o), 64'd1);
    tick();
    chk("t3_issue_valid", 64'(exe_valid_q_o), 64'd1);
    chk("t3_issue_rs1", 64'(rs1_data_qual_q_o), 64'h33);
    chk("t3_issue_rs2", 64'(rs2_data_qual_q_o), 64'h33);
    chk("t3_cnt", 64'(stall_cnt_q_o), 64'd2);

    // 4: backpressure for three cycles
    instr_q_i = AddiX1X0_5; pc0_q_i = 32'h300; ff_v_i = 2'b00;
    tick();
    chk("t4_first_pc", 64'(pc_q_o), 64'h300);
    exe_ready_i = 1'b0;
    instr_q_i = AddX2X1X1; pc0_q_i = 32'h304;
    ff_v_i = 2'b01; ff_adr_i = {5'd0, 5'd1}; ff_data_i = {32'd0, 32'd5};
    #1 chk("t4_ready_hold", 64'(dec_ready_o), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_hold_valid", 64'(exe_valid_q_o), 64'd1);
      chk("t4_hold_pc", 64'(pc_q_o), 64'h300);
      chk("t4_hold_rs2", 64'(rs2_data_qual_q_o), 64'd5);
      chk("t4_hold_rd", 64'(rd_adr_q_o), 64'd1);
    end
    exe_ready_i = 1'b1;
    #1 chk("t4_ready_release", 64'(dec_ready_o), 64'd1);
    tick();
    chk("t4_next_valid", 64'(exe_valid_q_o), 64'd1);
    chk("t4_next_pc", 64'(pc_q_o), 64'h304);

    // 5: flush while stalled
    instr_q_i = AddX6X5X5; pc0_q_i = 32'h400;
    ff_v_i = 2'b01; ff_pend_i = 2'b01; ff_adr_i = {5'd0, 5'd5}; ff_data_i = {32'd0, 32'h44};
    tick();
    chk("t5_bubble", 64'(exe_valid_q_o), 64'd0);
    tick();
    chk("t5_cnt_pre", 64'(stall_cnt_q_o), 64'd3);
    flush_v_i = 1'b1;
    #1 chk("t5_ready_flush", 64'(dec_ready_o), 64'd0);
    tick();
    chk("t5_flush_valid", 64'(exe_valid_q_o), 64'd0);
    chk("t5_flush_cnt", 64'(stall_cnt_q_o), 64'd3);
    flush_v_i = 1'b0; ff_pend_i = 2'b00;
    tick();
    chk("t5_after_valid", 64'(exe_valid_q_o), 64'd1);
    chk("t5_after_rs1", 64'(rs1_data_qual_q_o), 64'h44);
    chk("t5_after_cnt", 64'(stall_cnt_q_o), 64'd3);

    // 6: SUB negates rs2 to XLEN+1 bits; reset during hold
    instr_q_i = SubX1X2X3; pc0_q_i = 32'h500; ff_v_i = 2'b00;
    rf_rs1_data_i = 32'd0; rf_rs2_data_i = 32'd1;
    tick();
    chk("t6_sub_rs1", 64'(rs1_data_qual_q_o), 64'd0);
    chk("t6_sub_rs2", 64'(rs2_data_qual_q_o), 64'h1_FFFF_FFFF);
    exe_ready_i = 1'b0; if_valid_i = 1'b0;
    tick();
    chk("t6_hold_valid", 64'(exe_valid_q_o), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(exe_valid_q_o), 64'd0);
    chk("t6_rst_rs2", 64'(rs2_data_qual_q_o), 64'd0);
    chk("t6_rst_pc", 64'(pc_q_o), 64'd0);
    chk("t6_rst_cnt", 64'(stall_cnt_q_o), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
